fe_dr4_reorder: RTL and testbench

FE_DR4_REORDER -- requirements
Module: fe_dr4_reorder

---
 rtl/fe_dr4_reorder.sv | 131 +++++++++++++
 tb/tb_fe_dr4_reorder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_dr4_reorder.sv
// rtl/fe_dr4_reorder.sv - radix-4 digit-reversed to natural-order frame reorder buffer
//
// Purpose: accepts complex samples in base-4 digit-reversed order, stores each
// frame into one of two ping-pong banks at its natural address, and streams
// a completed bank out in natural order, one sample per cycle.
//
// Ports:
//   clk          - clock, rising edge
//   rst_async_n  - asynchronous active-low reset
//   i_valid      - input sample present
//   i_sof        - start of frame (qualified by i_valid)
//   i_data[1:0]  - input sample, [0]=I, [1]=Q, signed NBW_IN
//   o_valid      - o_data holds a natural-order sample
//   o_sof        - first output sample (index 0) of a frame
//   o_data[1:0]  - output sample, [0]=I, [1]=Q, signed NBW_IN
//   o_drop       - one-cycle pulse when a partial frame is discarded
module fe_dr4_reorder #(
    parameter int NBW_IN = 11,
    parameter int LOG4N  = 3
) (
    input  logic                     clk,
    input  logic                     rst_async_n,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic signed [NBW_IN-1:0] i_data [1:0],
    output logic                     o_valid,
    output logic                     o_sof,
    output logic signed [NBW_IN-1:0] o_data [1:0],
    output logic                     o_drop
);
    localparam int AW = 2 * LOG4N;
    localparam int N  = 1 << AW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_t;

    // Bank select is the address MSB: entries [0..N-1] bank 0, [N..2N-1] bank 1.
    logic signed [NBW_IN-1:0] r_mem_i [2*N];
    logic signed [NBW_IN-1:0] r_mem_q [2*N];

    logic            r_wr_bank;
    logic [AW-1:0]   r_wr_cnt;
    rd_state_t       r_rd_state;
    logic            r_rd_bank;
    logic [AW-1:0]   r_rd_cnt;

    logic [AW-1:0]   w_wr_addr;
    logic            w_frame_done;

    // Reverse the order of the LOG4N base-4 digits (2-bit groups) of k.
    function automatic logic [AW-1:0] digrev(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = '0;
        for (int d = 0; d < LOG4N; d++) begin
            r[2*d +: 2] = k[AW-2-2*d +: 2];
        end
        return r;
    endfunction

    // An i_sof sample is always index 0 regardless of where the counter was.
    assign w_wr_addr    = i_sof ? '0 : digrev(r_wr_cnt);
    // Frame completes when the N-th sample lands; an i_sof restarts instead.
    assign w_frame_done = i_valid && !i_sof && (r_wr_cnt == {AW{1'b1}});

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_mem_i[{r_wr_bank, w_wr_addr}] <= i_data[0];
            r_mem_q[{r_wr_bank, w_wr_addr}] <= i_data[1];
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_state <= ST_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_cnt   <= '0;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_drop     <= 1'b0;
            o_data[0]  <= '0;
            o_data[1]  <= '0;
        end else begin
            o_drop <= 1'b0;

            // Write side
            if (i_valid) begin
                if (i_sof) begin
                    r_wr_cnt <= AW'(1);
                    if (r_wr_cnt != '0) begin
                        o_drop <= 1'b1;
                    end
                end else begin
                    r_wr_cnt <= r_wr_cnt + AW'(1);
                end
            end
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
            end

            // Read side
            if (r_rd_state == ST_RUN) begin
                o_data[0] <= r_mem_i[{r_rd_bank, r_rd_cnt}];
                o_data[1] <= r_mem_q[{r_rd_bank, r_rd_cnt}];
                o_valid   <= 1'b1;
                o_sof     <= (r_rd_cnt == '0);
                r_rd_cnt  <= r_rd_cnt + AW'(1);
                if (r_rd_cnt == {AW{1'b1}}) begin
                    r_rd_state <= ST_IDLE;
                end
            end else begin
                o_valid <= 1'b0;
                o_sof   <= 1'b0;
            end

            // A completing frame overrides the read-side defaults above; when it
            // coincides with the last read of the previous frame the stream
            // continues without a gap.
            if (w_frame_done) begin
                r_rd_bank  <= r_wr_bank;
                r_rd_cnt   <= '0;
                r_rd_state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_fe_dr4_reorder.sv
// tb/tb_fe_dr4_reorder.sv - self-checking bench for fe_dr4_reorder
`timescale 1ns/1ps
module tb_fe_dr4_reorder;

    typedef struct {
        logic signed [10:0] i;
        logic signed [10:0] q;
        logic               sof;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_async_n = 1'b0;

    logic               i_valid = 1'b0;
    logic               i_sof = 1'b0;
    logic signed [10:0] i_data [1:0];
    logic               o_valid;
    logic               o_sof;
    logic signed [10:0] o_data [1:0];
    logic               o_drop;

    logic               i_valid3 = 1'b0;
    logic               i_sof3 = 1'b0;
    logic signed [10:0] i_data3 [1:0];
    logic               o_valid3;
    logic               o_sof3;
    logic signed [10:0] o_data3 [1:0];
    logic               o_drop3;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    int   run_left = 0;
    int   streak = 0;
    int   max_streak = 0;
    int   drop_cnt = 0;

    fe_dr4_reorder #(.NBW_IN(11), .LOG4N(2)) u_dut2 (
        .clk(clk), .rst_async_n(rst_async_n),
        .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
        .o_valid(o_valid), .o_sof(o_sof), .o_data(o_data), .o_drop(o_drop)
    );

    fe_dr4_reorder #(.NBW_IN(11), .LOG4N(3)) u_dut3 (
        .clk(clk), .rst_async_n(rst_async_n),
        .i_valid(i_valid3), .i_sof(i_sof3), .i_data(i_data3),
        .o_valid(o_valid3), .o_sof(o_sof3), .o_data(o_data3), .o_drop(o_drop3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // Natural index carried by stream position k: base-4 digits of k reversed.
    function automatic int mdr(input int k, input int digits);
        int r = 0;
        int v = k;
        for (int d = 0; d < digits; d++) begin
            r = r * 4 + (v % 4);
            v = v / 4;
        end
        return r;
    endfunction

    task automatic put(input logic v, input logic s, input logic signed [10:0] di, input logic signed [10:0] dq);
        i_valid   = v;
        i_sof     = s;
        i_data[0] = di;
        i_data[1] = dq;
        @(posedge clk);
        #1;
    endtask

    // Sends the first nsamp stream positions of a 16-point frame; a full
    // frame's natural-order contents are queued as the expected output.
    task automatic send_frame(input bit ramp, input bit gaps, input int nsamp, input int exp_drop);
        logic signed [10:0] ni [16];
        logic signed [10:0] nq [16];
        exp_t x;
        for (int n = 0; n < 16; n++) begin
            ni[n] = ramp ? 11'(n)  : 11'($urandom);
            nq[n] = ramp ? 11'(-n) : 11'($urandom);
        end
        for (int k = 0; k < nsamp; k++) begin
            if (gaps) begin
                repeat ($urandom_range(2, 0)) put(1'b0, 1'b0, 11'($urandom), 11'($urandom));
            end
            put(1'b1, k == 0, ni[mdr(k, 2)], nq[mdr(k, 2)]);
            if (k == 0) check("drop_on_sof", int'(o_drop), exp_drop);
            if (k == 1) check("drop_single_cycle", int'(o_drop), 0);
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        if (nsamp == 16) begin
            for (int n = 0; n < 16; n++) begin
                x.i = ni[n];
                x.q = nq[n];
                x.sof = (n == 0);
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
        check("idle_after_drain", int'(o_valid), 0);
    endtask

    always @(negedge clk) begin
        if (rst_async_n) begin
            if (o_valid) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_i", int'(o_data[0]), int'(e.i));
                    check("out_q", int'(o_data[1]), int'(e.q));
                    check("out_sof", int'(o_sof), int'(e.sof));
                    if (e.sof) run_left = 15;
                    else if (run_left > 0) run_left--;
                end
            end else begin
                streak = 0;
                check("sof_while_idle", int'(o_sof), 0);
                check("gap_inside_frame", run_left, 0);
                run_left = 0;
            end
            if (o_drop) drop_cnt++;
        end
    end

    initial begin : main
        int lat;
        int drops0;
        logic signed [10:0] n3i [64];
        logic signed [10:0] n3q [64];

        i_data[0] = '0;  i_data[1] = '0;
        i_data3[0] = '0; i_data3[1] = '0;

        // Reset state
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_sof", int'(o_sof), 0);
        check("rst_drop", int'(o_drop), 0);
        check("rst_data_i", int'(o_data[0]), 0);
        check("rst_data_q", int'(o_data[1]), 0);
        check("rst_valid3", int'(o_valid3), 0);
        check("rst_drop3", int'(o_drop3), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_async_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", int'(o_valid), 0);

        // Ramp frame: I=digrev(k), Q=-digrev(k); output appears two cycles on
        send_frame(1'b1, 1'b0, 16, 0);
        @(negedge clk);
        check("latency_not_early", int'(o_valid), 0);
        @(posedge clk);
        #1;
        check("latency_valid", int'(o_valid), 1);
        check("latency_sof", int'(o_sof), 1);
        check("first_i_zero", int'(o_data[0]), 0);
        drain();

        // Three back-to-back full-rate frames
        max_streak = 0;
        drops0 = drop_cnt;
        for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b0, 16, 0);
        drain();
        check("b2b_contiguous_len", max_streak, 48);
        check("b2b_no_drop", drop_cnt - drops0, 0);

        // Partial frame discarded by an early i_sof at wr_cnt=7
        drops0 = drop_cnt;
        send_frame(1'b0, 1'b0, 7, 0);
        send_frame(1'b0, 1'b0, 16, 1);
        drain();
        check("drop_pulse_count", drop_cnt - drops0, 1);

        // Random ~50% i_valid gaps
        max_streak = 0;
        for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b1, 16, 0);
        drain();
        check("gap_frames_len", max_streak, 16);

        // Reset during readout at rd_cnt=5
        send_frame(1'b0, 1'b0, 16, 0);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_valid", int'(o_valid), 1);
        rst_async_n = 1'b0;
        #1;
        check("reset_kills_valid", int'(o_valid), 0);
        check("reset_clears_data", int'(o_data[0]), 0);
        exp_q.delete();
        run_left = 0;
        streak = 0;
        @(posedge clk);
        #1;
        rst_async_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("no_output_after_reset", int'(o_valid), 0);
        send_frame(1'b1, 1'b0, 16, 0);
        drain();

        // LOG4N=3 single frame against the digit-reversal model
        for (int n = 0; n < 64; n++) begin
            n3i[n] = 11'($urandom);
            n3q[n] = 11'($urandom);
        end
        for (int k = 0; k < 64; k++) begin
            i_valid3   = 1'b1;
            i_sof3     = (k == 0);
            i_data3[0] = n3i[mdr(k, 3)];
            i_data3[1] = n3q[mdr(k, 3)];
            @(posedge clk);
            #1;
        end
        i_valid3 = 1'b0;
        i_sof3   = 1'b0;
        lat = 0;
        while (!o_valid3 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("n64_latency", lat, 1);
        for (int n = 0; n < 64; n++) begin
            check("n64_valid", int'(o_valid3), 1);
            check("n64_sof", int'(o_sof3), (n == 0) ? 1 : 0);
            check("n64_i", int'(o_data3[0]), int'(n3i[n]));
            check("n64_q", int'(o_data3[1]), int'(n3q[n]));
            @(posedge clk);
            #1;
        end
        check("n64_end_idle", int'(o_valid3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
